fifo_flags: RTL and testbench



---
 rtl/fifo_flags_if.sv | 39 +++
 rtl/fifo_flags.sv | 79 +++++++
 tb/tb_fifo_flags.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_flags_if.sv
// Handshake bundle for the fifo_flags FWFT buffer.
// Optional overflow/underflow/err_clear signals exist only when FIFO_FLAGS_ERR_EN is defined.
interface fifo_flags_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
);
   logic                  write_en;
   logic [DATA_WIDTH-1:0] write_data;
   logic                  read_en;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  empty;
   logic                  full;
   logic                  almost_empty;
   logic                  almost_full;
   logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_FLAGS_ERR_EN
   logic                  err_clear;
   logic                  overflow;
   logic                  underflow;
`endif

   modport master (
`ifdef FIFO_FLAGS_ERR_EN
      output err_clear,
      input  overflow, underflow,
`endif
      output write_en, write_data, read_en,
      input  read_data, empty, full, almost_empty, almost_full, count
   );

   modport slave (
`ifdef FIFO_FLAGS_ERR_EN
      input  err_clear,
      output overflow, underflow,
`endif
      input  write_en, write_data, read_en,
      output read_data, empty, full, almost_empty, almost_full, count
   );
endinterface

// File: rtl/fifo_flags.sv
// Single-clock first-word-fall-through FIFO with occupancy count and almost flags.
// Define FIFO_FLAGS_ERR_EN to add sticky overflow/underflow outputs with synchronous err_clear.
module fifo_flags #(
   parameter int DATA_WIDTH          = 8,
   parameter int ADDR_WIDTH          = 4,
   parameter int ALMOST_FULL_MARGIN  = 2,
   parameter int ALMOST_EMPTY_MARGIN = 2
) (
   input  logic         clk,
   input  logic         reset_n,
   fifo_flags_if.slave  bus
);
   localparam int DEPTH = 2**ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH+1)'(DEPTH - ALMOST_FULL_MARGIN);
   localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_MARGIN);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  wr_ok;
   logic                  rd_ok;

   // Acceptance uses the flags registered before the edge, so a write
   // into a full FIFO is dropped even when a read frees a slot that cycle.
   assign wr_ok = bus.write_en && !bus.full;
   assign rd_ok = bus.read_en  && !bus.empty;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= bus.write_data;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, rd_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign bus.read_data    = mem[rd_ptr];
   assign bus.count        = count_q;
   assign bus.empty        = (count_q == '0);
   assign bus.full         = (count_q == FULL_LEVEL);
   assign bus.almost_empty = (count_q <= AE_LEVEL);
   assign bus.almost_full  = (count_q >= AF_LEVEL);

`ifdef FIFO_FLAGS_ERR_EN
   logic overflow_q;
   logic underflow_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else if (bus.err_clear) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.write_en && bus.full)  overflow_q  <= 1'b1;
         if (bus.read_en  && bus.empty) underflow_q <= 1'b1;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo_flags.sv
// Directed self-checking bench for fifo_flags at DEPTH=8, both margins 2.
// Build with FIFO_FLAGS_ERR_EN defined to also cover the sticky error flags.
module tb_fifo_flags;
   logic clk;
   logic reset_n;
   int   n_tests;
   int   n_fail;

   fifo_flags_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus ();

   fifo_flags #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(3),
      .ALMOST_FULL_MARGIN(2),
      .ALMOST_EMPTY_MARGIN(2)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_count"}, 32'(bus.count), 0);
      chk({tag, "_empty"}, 32'(bus.empty), 1);
      chk({tag, "_aempty"}, 32'(bus.almost_empty), 1);
      chk({tag, "_full"}, 32'(bus.full), 0);
      chk({tag, "_afull"}, 32'(bus.almost_full), 0);
`ifdef FIFO_FLAGS_ERR_EN
      chk({tag, "_ovf"}, 32'(bus.overflow), 0);
      chk({tag, "_unf"}, 32'(bus.underflow), 0);
`endif
   endtask

   initial begin
      int   mcount;
      logic [7:0] wr_val;
      logic [7:0] rd_val;
      logic       m_wr;
      logic       m_rd;

      n_tests = 0;
      n_fail  = 0;
      reset_n = 1'b0;
      bus.write_en   = 1'b0;
      bus.write_data = '0;
      bus.read_en    = 1'b0;
`ifdef FIFO_FLAGS_ERR_EN
      bus.err_clear  = 1'b0;
`endif
      tick();
      tick();
      chk_reset_outputs("rst");
      @(negedge clk);
      reset_n = 1'b1;
      tick();
      chk_reset_outputs("idle");

      // fill 0x10..0x17
      for (int i = 0; i < 8; i++) begin
         bus.write_en   = 1'b1;
         bus.write_data = 8'(8'h10 + i);
         tick();
         chk("fill_count", 32'(bus.count), 32'(i + 1));
         chk("fill_head", 32'(bus.read_data), 32'h10);
         chk("fill_aempty", 32'(bus.almost_empty), (i + 1 <= 2) ? 1 : 0);
         chk("fill_afull", 32'(bus.almost_full), (i + 1 >= 6) ? 1 : 0);
         chk("fill_full", 32'(bus.full), (i == 7) ? 1 : 0);
         chk("fill_empty", 32'(bus.empty), 0);
      end

      bus.write_data = 8'hFF;
      tick();
      chk("ovf_count", 32'(bus.count), 8);
      chk("ovf_head", 32'(bus.read_data), 32'h10);
`ifdef FIFO_FLAGS_ERR_EN
      chk("ovf_flag", 32'(bus.overflow), 1);
      bus.err_clear = 1'b1;
      tick();
      chk("ovf_clear_prio", 32'(bus.overflow), 0);
      bus.err_clear = 1'b0;
`endif

      // read+write while full: read wins, write dropped
      bus.write_data = 8'h20;
      bus.read_en    = 1'b1;
      tick();
      chk("rw_full_count", 32'(bus.count), 7);
      chk("rw_full_full", 32'(bus.full), 0);
      chk("rw_full_head", 32'(bus.read_data), 32'h11);
      bus.write_en = 1'b0;

      for (int i = 0; i < 7; i++) begin
         chk("drain_head", 32'(bus.read_data), 32'(8'h11 + i));
         tick();
      end
      bus.read_en = 1'b0;
      chk("drain_count", 32'(bus.count), 0);
      chk("drain_empty", 32'(bus.empty), 1);

      // read+write while empty: write wins
      bus.write_en   = 1'b1;
      bus.write_data = 8'h33;
      bus.read_en    = 1'b1;
      tick();
      chk("rw_empty_count", 32'(bus.count), 1);
      chk("rw_empty_head", 32'(bus.read_data), 32'h33);
      chk("rw_empty_empty", 32'(bus.empty), 0);
`ifdef FIFO_FLAGS_ERR_EN
      chk("unf_flag", 32'(bus.underflow), 1);
`endif
      bus.write_en = 1'b0;
      tick();
      bus.read_en = 1'b0;
      chk("pop_33_empty", 32'(bus.empty), 1);

      // interleaved: write always requested, read every 3rd cycle
      mcount = 0;
      wr_val = 8'h40;
      rd_val = 8'h40;
      for (int c = 0; c < 512; c++) begin
         bus.write_en   = 1'b1;
         bus.write_data = wr_val;
         bus.read_en    = (c % 3 == 0);
         m_wr = (mcount != 8);
         m_rd = bus.read_en && (mcount != 0);
         #1;
         if (m_rd) chk("mix_data", 32'(bus.read_data), 32'(rd_val));
         tick();
         if (m_wr) wr_val = wr_val + 8'd1;
         if (m_rd) rd_val = rd_val + 8'd1;
         mcount = mcount + (m_wr ? 1 : 0) - (m_rd ? 1 : 0);
         chk("mix_count", 32'(bus.count), 32'(mcount));
      end
      bus.write_en = 1'b0;
      bus.read_en  = 1'b0;

      // async reset mid-stream at count=5
      reset_n = 1'b0;
      #1;
      reset_n = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         bus.write_en   = 1'b1;
         bus.write_data = 8'(8'hA0 + i);
         tick();
      end
      bus.write_en = 1'b0;
      chk("pre_rst_count", 32'(bus.count), 5);
      #2;
      reset_n = 1'b0;
      #1;
      chk_reset_outputs("async_rst");
      @(negedge clk);
      reset_n = 1'b1;
      bus.write_en   = 1'b1;
      bus.write_data = 8'h5A;
      tick();
      bus.write_en = 1'b0;
      chk("post_rst_head", 32'(bus.read_data), 32'h5A);
      chk("post_rst_empty", 32'(bus.empty), 0);
      chk("post_rst_count", 32'(bus.count), 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
